booth_csa_seq: RTL

// - Iterative radix-4 Booth multiplier front end. Each cycle it adds one Booth partial product

---
 rtl/booth_csa_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/booth_csa_seq.sv
// booth_csa_seq
// Iterative radix-4 Booth multiplier front end. Each RUN cycle adds one Booth partial product
// into a 2W-bit carry-save (sum, carry) accumulator using a row of 3:2 compressors. The
// resulting redundant pair is meant to be resolved by a downstream carry-lookahead adder
// (a = sum_o, b = carry_o, c_in = 0). One multiply is in flight at a time.
//
// Parameters:
//   W       operand width (even, >= 4)
//   SIGNED  1: two's-complement operands, 0: unsigned operands (zero-extended by 2 bits)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept operands (high only in IDLE)
//   a_i        in   [W-1:0]   multiplicand
//   b_i        in   [W-1:0]   multiplier, Booth-recoded internally
//   out_valid  out  sum_o/carry_o hold a completed result (high only in DONE)
//   out_ready  in   consumer accepts the result
//   sum_o      out  [2W-1:0]  carry-save sum vector
//   carry_o    out  [2W-1:0]  carry-save carry vector, already aligned
//
// Optional feature macro: BOOTH_CSA_ZERO_SKIP_EN
//   When defined, RUN exits early once every remaining Booth digit decodes to zero.
//   Results are unchanged; only latency shrinks. Undefined: fixed N-cycle RUN.

module booth_csa_seq #(
  parameter int W      = 8,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   sum_o,
  output logic [2*W-1:0]   carry_o
);

  localparam int N  = (SIGNED != 0) ? W / 2 : W / 2 + 1;
  localparam int BW = 2 * N;
  localparam int PW = 2 * W;
  localparam int KW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic            b_prev_q, b_prev_d;
  logic [PW-1:0]   acc_s_q, acc_s_d;
  logic [PW-1:0]   acc_c_q, acc_c_d;
  logic [KW-1:0]   k_q, k_d;

  logic [PW-1:0]   a_ext;
  logic [BW-1:0]   b_ext;
  logic [2:0]      triplet;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   csa_sum;
  logic [PW-1:0]   csa_maj;
  logic [BW-1:0]   b_next;
  logic            last_digit;

  // Operand extension: multiplicand goes straight to 2W bits so every partial product is
  // already sign-correct modulo 2^2W; unsigned multipliers get two zero bits so the top
  // Booth digit never sees a spurious sign.
  if (SIGNED != 0) begin : g_signed_ext
    assign a_ext = {{W{a_i[W-1]}}, a_i};
    assign b_ext = b_i;
  end else begin : g_unsigned_ext
    assign a_ext = {{W{1'b0}}, a_i};
    assign b_ext = {2'b00, b_i};
  end

  // Datapath for one RUN step. The multiplier register shifts right by two each step, so the
  // current digit always lives in b_q[1:0] plus the previously shifted-out bit; likewise the
  // multiplicand register shifts left by two, which provides the << 2k weighting for free.
  // Doubling/negating in 2W bits keeps the -2 * most-negative case exact modulo 2^2W.
  always_comb begin
    triplet = {b_q[1], b_q[0], b_prev_q};
    pp      = '0;
    case (triplet)
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
    csa_sum = acc_s_q ^ acc_c_q ^ pp;
    csa_maj = (acc_s_q & acc_c_q) | (acc_s_q & pp) | (acc_c_q & pp);
    b_next  = {b_q[BW-1], b_q[BW-1], b_q[BW-1:2]};
`ifdef BOOTH_CSA_ZERO_SKIP_EN
    // Remaining digits are all zero exactly when the unconsumed multiplier bits, including
    // the overlap bit b_q[1], form a run of identical bits.
    last_digit = (k_q == KW'(N - 1)) || (b_next == {BW{b_q[1]}});
`else
    last_digit = (k_q == KW'(N - 1));
`endif
  end

  // Next-state and register-update logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    b_prev_d = b_prev_q;
    acc_s_d  = acc_s_q;
    acc_c_d  = acc_c_q;
    k_d      = k_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a_ext;
          b_d      = b_ext;
          b_prev_d = 1'b0;
          acc_s_d  = '0;
          acc_c_d  = '0;
          k_d      = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_s_d  = csa_sum;
        acc_c_d  = csa_maj << 1;
        a_d      = a_q << 2;
        b_d      = b_next;
        b_prev_d = b_q[1];
        k_d      = k_q + KW'(1);
        if (last_digit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      b_prev_q <= 1'b0;
      acc_s_q  <= '0;
      acc_c_q  <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      b_prev_q <= b_prev_d;
      acc_s_q  <= acc_s_d;
      acc_c_q  <= acc_c_d;
      k_q      <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum_o     = acc_s_q;
  assign carry_o   = acc_c_q;

endmodule
